// File: rtl/adder_seq_pkg.sv
// Shared types and widths for the adder_tree_seq sequencer.
// Widths cover the worst case 15+15+255+255 = 540 without truncation.
package adder_seq_pkg;

    localparam int A_W  = 4;
    localparam int C_W  = 8;
    localparam int S1_W = 5;
    localparam int S2_W = 9;
    localparam int S3_W = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADD_AB  = 3'd1,
        ADD_CD  = 3'd2,
        ADD_FIN = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/adder_tree_seq_shared_adder.sv
// Single combinational 10-bit unsigned adder reused by every step of the tree.
// Callers zero-extend narrower operands before presenting them.
module shared_adder
    import adder_seq_pkg::*;
(
    input  logic [S3_W-1:0] x,
    input  logic [S3_W-1:0] y,
    output logic [S3_W-1:0] sum
);

    assign sum = x + y;

endmodule

// File: rtl/adder_tree_seq.sv
// Computes sum3 = (a + b) + (c + d) over three cycles with one shared adder.
// Optional partial-sum ports sum1/sum2 appear when ADDER_SEQ_PARTIALS_EN is defined.
module adder_tree_seq
    import adder_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [A_W-1:0]   b,
    input  logic [C_W-1:0]   c,
    input  logic [C_W-1:0]   d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [S3_W-1:0]  sum3,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
`ifdef ADDER_SEQ_PARTIALS_EN
    ,
    output logic [S1_W-1:0]  sum1,
    output logic [S2_W-1:0]  sum2
`endif
);

    state_t state;
    state_t next_state;

    logic [A_W-1:0]   a_q;
    logic [A_W-1:0]   b_q;
    logic [C_W-1:0]   c_q;
    logic [C_W-1:0]   d_q;
    logic [S1_W-1:0]  sum1_q;
    logic [S2_W-1:0]  sum2_q;
    logic [S3_W-1:0]  sum3_q;
    logic [CNT_W-1:0] done_cnt_q;

    logic [S3_W-1:0]  add_x;
    logic [S3_W-1:0]  add_y;
    logic [S3_W-1:0]  add_sum;

    shared_adder u_shared_adder (
        .x   (add_x),
        .y   (add_y),
        .sum (add_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake flags depend on state alone, so no input reaches an output combinationally.
    always_comb begin
        next_state = state;
        add_x      = '0;
        add_y      = '0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    next_state = ADD_AB;
                end
            end
            ADD_AB: begin
                add_x      = {{(S3_W-A_W){1'b0}}, a_q};
                add_y      = {{(S3_W-A_W){1'b0}}, b_q};
                next_state = ADD_CD;
            end
            ADD_CD: begin
                add_x      = {{(S3_W-C_W){1'b0}}, c_q};
                add_y      = {{(S3_W-C_W){1'b0}}, d_q};
                next_state = ADD_FIN;
            end
            ADD_FIN: begin
                add_x      = {{(S3_W-S1_W){1'b0}}, sum1_q};
                add_y      = {{(S3_W-S2_W){1'b0}}, sum2_q};
                next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            sum1_q     <= '0;
            sum2_q     <= '0;
            sum3_q     <= '0;
            done_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                        c_q <= c;
                        d_q <= d;
                    end
                end
                ADD_AB: begin
                    sum1_q <= add_sum[S1_W-1:0];
                end
                ADD_CD: begin
                    sum2_q <= add_sum[S2_W-1:0];
                end
                ADD_FIN: begin
                    sum3_q <= add_sum;
                end
                DONE: begin
                    if (out_ready) begin
                        done_cnt_q <= done_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum3     = sum3_q;
    assign done_cnt = done_cnt_q;

`ifdef ADDER_SEQ_PARTIALS_EN
    assign sum1 = sum1_q;
    assign sum2 = sum2_q;
`endif

endmodule

// File: tb/tb_adder_tree_seq.sv
// Self-checking bench for adder_tree_seq: table vectors, hand-written corner sequences, random traffic.
// Built with CNT_W=2 so the completion counter wrap is reachable quickly.
module tb_adder_tree_seq;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [3:0]       a = '0;
    logic [3:0]       b = '0;
    logic [7:0]       c = '0;
    logic [7:0]       d = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [9:0]       sum3;
    logic [CNT_W-1:0] done_cnt;
`ifdef ADDER_SEQ_PARTIALS_EN
    logic [4:0]       sum1;
    logic [8:0]       sum2;
`endif

    int checks = 0;
    int passes = 0;
    int exp_cnt = 0;
    int cycle = 0;

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int exp_sum;
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    adder_tree_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum3      (sum3),
        .busy      (busy),
        .done_cnt  (done_cnt)
`ifdef ADDER_SEQ_PARTIALS_EN
        ,
        .sum1      (sum1),
        .sum2      (sum2)
`endif
    );

    // Reference model: the tree sum is plain integer addition; the counter is modulo 2^CNT_W.
    function automatic int model_sum(input int va, input int vb, input int vc, input int vd);
        return va + vb + vc + vd;
    endfunction

    function automatic int model_cnt_next(input int n);
        return (n + 1) % (1 << CNT_W);
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) step();
        rst_n   = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic wait_out_valid(input string tag);
        int guard;
        guard = 0;
        while (!out_valid && guard < 20) begin
            step();
            guard++;
        end
        if (!out_valid) check_output({tag, ".out_valid_timeout"}, 0, 1);
    endtask

    // One full transaction: accept, check the three-step latency, stall, then hand off.
    task automatic apply_stimulus(input int ta, input int tb, input int tc, input int td,
                                  input int exp_sum, input int stall, input string tag);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!in_ready) check_output({tag, ".in_ready_timeout"}, 0, 1);
        a = ta[3:0];
        b = tb[3:0];
        c = tc[7:0];
        d = td[7:0];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_output({tag, ".busy_after_accept"}, int'(busy), 1);
        check_output({tag, ".in_ready_after_accept"}, int'(in_ready), 0);
        step();
        check_output({tag, ".out_valid_k1"}, int'(out_valid), 0);
`ifdef ADDER_SEQ_PARTIALS_EN
        check_output({tag, ".sum1"}, int'(sum1), ta + tb);
`endif
        step();
        check_output({tag, ".out_valid_k2"}, int'(out_valid), 0);
`ifdef ADDER_SEQ_PARTIALS_EN
        check_output({tag, ".sum2"}, int'(sum2), tc + td);
`endif
        step();
        check_output({tag, ".out_valid_k3"}, int'(out_valid), 1);
        check_output({tag, ".sum3"}, int'(sum3), exp_sum);
        for (int i = 0; i < stall; i++) begin
            step();
            check_output({tag, ".stall_out_valid"}, int'(out_valid), 1);
            check_output({tag, ".stall_sum3"}, int'(sum3), exp_sum);
            check_output({tag, ".stall_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt = model_cnt_next(exp_cnt);
        check_output({tag, ".done_cnt"}, int'(done_cnt), exp_cnt);
        check_output({tag, ".out_valid_after_hs"}, int'(out_valid), 0);
        check_output({tag, ".in_ready_after_hs"}, int'(in_ready), 1);
    endtask

    initial begin
        vec_t vecs[5];
        int   ra, rb, rc, rd, last_cycle;

        vecs[0] = '{a: 15, b: 15, c: 255, d: 255, exp_sum: 540};
        vecs[1] = '{a: 3,  b: 4,  c: 10,  d: 20,  exp_sum: 37};
        vecs[2] = '{a: 0,  b: 0,  c: 0,   d: 0,   exp_sum: 0};
        vecs[3] = '{a: 1,  b: 1,  c: 1,   d: 1,   exp_sum: 4};
        vecs[4] = '{a: 15, b: 0,  c: 0,   d: 255, exp_sum: 270};

        do_reset();
        check_output("reset.in_ready", int'(in_ready), 1);
        check_output("reset.out_valid", int'(out_valid), 0);
        check_output("reset.busy", int'(busy), 0);
        check_output("reset.sum3", int'(sum3), 0);
        check_output("reset.done_cnt", int'(done_cnt), 0);
`ifdef ADDER_SEQ_PARTIALS_EN
        check_output("reset.sum1", int'(sum1), 0);
        check_output("reset.sum2", int'(sum2), 0);
`endif

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d,
                           vecs[i].exp_sum, i % 3, $sformatf("vec%0d", i));
        end

        apply_stimulus(3, 4, 10, 20, 37, 5, "backpressure");

        // Operands offered during ADD_CD must be ignored, then taken once back in IDLE.
        a = 4'd3; b = 4'd4; c = 8'd10; d = 8'd20;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        a = 4'd1; b = 4'd1; c = 8'd1; d = 8'd1;
        in_valid = 1'b1;
        check_output("ignore.in_ready_add_cd", int'(in_ready), 0);
        step();
        step();
        check_output("ignore.out_valid", int'(out_valid), 1);
        check_output("ignore.sum3_first", int'(sum3), 37);
        repeat (2) step();
        check_output("ignore.sum3_held", int'(sum3), 37);
        check_output("ignore.in_ready_done", int'(in_ready), 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt = model_cnt_next(exp_cnt);
        check_output("ignore.done_cnt_first", int'(done_cnt), exp_cnt);
        check_output("ignore.in_ready_idle", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check_output("ignore.busy_second", int'(busy), 1);
        wait_out_valid("ignore");
        check_output("ignore.sum3_second", int'(sum3), 4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_cnt = model_cnt_next(exp_cnt);
        check_output("ignore.done_cnt_second", int'(done_cnt), exp_cnt);

        // Reset while in ADD_FIN discards the transaction entirely.
        a = 4'd5; b = 4'd6; c = 8'd7; d = 8'd8;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        exp_cnt = 0;
        check_output("midreset.out_valid", int'(out_valid), 0);
        check_output("midreset.in_ready", int'(in_ready), 1);
        check_output("midreset.busy", int'(busy), 0);
        check_output("midreset.done_cnt", int'(done_cnt), exp_cnt);
        check_output("midreset.sum3", int'(sum3), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        check_output("midreset.no_late_out_valid", int'(out_valid), 0);
        check_output("midreset.done_cnt_after", int'(done_cnt), exp_cnt);

        for (int i = 0; i < 20; i++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            rc = int'($urandom_range(0, 255));
            rd = int'($urandom_range(0, 255));
            apply_stimulus(ra, rb, rc, rd, model_sum(ra, rb, rc, rd),
                           int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        // Back-to-back traffic with both handshakes held high: counter wraps 1,2,3,0,1.
        do_reset();
        a = 4'd2; b = 4'd3; c = 8'd4; d = 8'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        last_cycle = 0;
        for (int i = 0; i < 5; i++) begin
            wait_out_valid($sformatf("wrap%0d", i));
            check_output($sformatf("wrap%0d.sum3", i), int'(sum3), model_sum(2, 3, 4, 5));
            if (i > 0) check_output($sformatf("wrap%0d.period", i), cycle - last_cycle, 5);
            last_cycle = cycle;
            step();
            if (i == 4) in_valid = 1'b0;
            exp_cnt = model_cnt_next(exp_cnt);
            check_output($sformatf("wrap%0d.done_cnt", i), int'(done_cnt), exp_cnt);
        end
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
